// File: rtl/unpack_copy.sv
// unpack_copy: splits packed 112-bit mem1 words into four 28-bit mem0 writes, high slice first
module unpack_copy #(
  parameter int OWL = 28,
  parameter int RATIO = 4,
  parameter int IWL = OWL * RATIO,
  parameter int NIN = 9,
  parameter int IAW = 4,
  parameter int OAW = 6
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  input  logic           iCLR,
  input  logic           iSTART,
  output logic [IAW-1:0] mem1readADDR,
  input  logic [IWL-1:0] mem1readDATA,
  output logic [OAW-1:0] mem0writeADDR,
  output logic [OWL-1:0] mem0writeDATA,
  output logic           mem0writeEN,
  output logic           oBUSY,
  output logic           oDONE
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EMIT, DONE} state_t;
  localparam logic [IAW-1:0] LAST = IAW'(NIN);
  state_t state, state_nx;
  logic [IAW-1:0] rd_cnt;
  logic [OAW-1:0] wr_cnt;
  logic [1:0] sub_cnt;
  logic [IWL-1:0] shift;
  logic start;
  always_comb begin
    start = (state == IDLE || state == DONE) && iSTART;
    state_nx = iCLR                    ? IDLE :
               start                   ? FETCH :
               state == FETCH          ? LOAD :
               state == LOAD           ? EMIT :
               state == EMIT && &sub_cnt ? (rd_cnt == LAST ? DONE : FETCH) :
               state;
  end
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      sub_cnt <= '0;
      shift <= '0;
      mem1readADDR <= '0;
    end else if (iCLR) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      sub_cnt <= '0;
      shift <= '0;
      mem1readADDR <= '0;
    end else begin
      if (start) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (state_nx == FETCH) mem1readADDR <= start ? '0 : rd_cnt;
      if (state == LOAD) begin
        shift <= mem1readDATA;
        sub_cnt <= '0;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (state == EMIT) begin
        shift <= {shift[IWL-OWL-1:0], OWL'(0)};
        wr_cnt <= wr_cnt + 1'b1;
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end
  assign oBUSY = state == FETCH || state == LOAD || state == EMIT;
  assign oDONE = state == DONE;
  assign mem0writeEN = state == EMIT;
  assign mem0writeADDR = mem0writeEN ? wr_cnt : '0;
  assign mem0writeDATA = mem0writeEN ? shift[IWL-1 -: OWL] : '0;
endmodule

// File: tb/tb_unpack_copy.sv
// tb_unpack_copy: scoreboard bench for unpack_copy with mem1/mem0 models
module tb_unpack_copy;
  logic iCLK = 0;
  logic iRSTn = 0;
  logic iCLR = 0;
  logic iSTART = 0;
  logic [3:0] mem1readADDR;
  logic [111:0] mem1readDATA;
  logic [5:0] mem0writeADDR;
  logic [27:0] mem0writeDATA;
  logic mem0writeEN;
  logic oBUSY;
  logic oDONE;
  logic [111:0] mem1 [16];
  logic [27:0] mem0 [64];
  logic [27:0] orig [36];
  logic [33:0] exp_q [$];
  int vectors = 0;
  int errs = 0;
  int wcount = 0;
  int max_addr = 0;
  unpack_copy dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iSTART(iSTART),
    .mem1readADDR(mem1readADDR), .mem1readDATA(mem1readDATA),
    .mem0writeADDR(mem0writeADDR), .mem0writeDATA(mem0writeDATA),
    .mem0writeEN(mem0writeEN), .oBUSY(oBUSY), .oDONE(oDONE)
  );
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) mem1readDATA <= mem1[mem1readADDR];
  always @(posedge iCLK) if (mem0writeEN) mem0[mem0writeADDR] <= mem0writeDATA;
  always @(negedge iCLK) begin
    if (iRSTn && mem0writeEN) begin
      logic [33:0] e;
      wcount++;
      if (int'(mem0writeADDR) > max_addr) max_addr = int'(mem0writeADDR);
      vectors++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: addr=%0d data=%h, expected no write", mem0writeADDR, mem0writeDATA);
      end else begin
        e = exp_q.pop_front();
        if ({mem0writeADDR, mem0writeDATA} !== e) begin
          errs++;
          $display("FAIL write: addr=%0d data=%h, expected addr=%0d data=%h", mem0writeADDR, mem0writeDATA, e[33:28], e[27:0]);
        end
      end
    end
  end
  task automatic tick();
    @(posedge iCLK);
    @(negedge iCLK);
    #1;
  endtask
  task automatic clear_mem0();
    for (int i = 0; i < 64; i++) mem0[i] = '0;
  endtask
  task automatic push_expect();
    for (int n = 0; n < 36; n++) begin
      logic [111:0] w;
      w = mem1[n / 4];
      exp_q.push_back({6'(n), w[111 - 28 * (n % 4) -: 28]});
    end
  endtask
  task automatic start_pulse();
    iSTART = 1;
    tick();
    iSTART = 0;
  endtask
  task automatic run_collect(input int p1, input int p2, output int busy, output int done_at);
    busy = 0;
    done_at = 0;
    for (int c = 1; c <= 60; c++) begin
      if (oBUSY) busy++;
      if (oDONE && done_at == 0) done_at = c;
      iSTART = (c == p1 || c == p2);
      tick();
      iSTART = 0;
    end
  endtask
  task automatic test_reset();
    iRSTn = 0;
    tick();
    vectors++;
    if ({oBUSY, oDONE, mem0writeEN, mem1readADDR, mem0writeADDR, mem0writeDATA} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b ra=%0d wa=%0d wd=%h, expected all 0", oBUSY, oDONE, mem0writeEN, mem1readADDR, mem0writeADDR, mem0writeDATA);
    end
    iRSTn = 1;
    tick();
    vectors++;
    if (oBUSY !== 0 || oDONE !== 0) begin
      errs++;
      $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", oBUSY, oDONE);
    end
  endtask
  task automatic check_run(input string tag, input int p1, input int p2);
    int busy, done_at, bad;
    wcount = 0;
    max_addr = 0;
    push_expect();
    start_pulse();
    vectors++;
    if (mem1readADDR !== 4'd0 || oBUSY !== 1 || oDONE !== 0) begin
      errs++;
      $display("FAIL %s_first_fetch: ra=%0d busy=%b done=%b, expected 0 1 0", tag, mem1readADDR, oBUSY, oDONE);
    end
    run_collect(p1, p2, busy, done_at);
    vectors++;
    if (busy != 54) begin
      errs++;
      $display("FAIL %s_busy_cycles: got %0d, expected 54", tag, busy);
    end
    vectors++;
    if (done_at != 55) begin
      errs++;
      $display("FAIL %s_done_cycle: got %0d, expected 55", tag, done_at);
    end
    vectors++;
    if (wcount != 36 || exp_q.size() != 0) begin
      errs++;
      $display("FAIL %s_write_count: got %0d (left %0d), expected 36 (left 0)", tag, wcount, exp_q.size());
    end
    vectors++;
    if (max_addr != 35) begin
      errs++;
      $display("FAIL %s_max_addr: got %0d, expected 35", tag, max_addr);
    end
    bad = 0;
    for (int n = 0; n < 36; n++) if (mem0[n] !== 28'(n)) bad++;
    vectors++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s_mem0_contents: %0d bad entries, expected 0", tag, bad);
    end
  endtask
  task automatic test_full_run();
    for (int k = 0; k < 16; k++) mem1[k] = {28'(4 * k), 28'(4 * k + 1), 28'(4 * k + 2), 28'(4 * k + 3)};
    clear_mem0();
    check_run("full", 0, 0);
  endtask
  task automatic test_back_to_back();
    clear_mem0();
    check_run("busy_start", 5, 30);
    clear_mem0();
    check_run("rerun", 0, 0);
  endtask
  task automatic test_abort();
    int busy, done_at;
    push_expect();
    start_pulse();
    for (int c = 1; c < 20; c++) tick();
    iCLR = 1;
    tick();
    iCLR = 0;
    vectors++;
    if ({oBUSY, oDONE, mem0writeEN, mem1readADDR, mem0writeADDR, mem0writeDATA} !== '0) begin
      errs++;
      $display("FAIL abort_outputs: busy=%b done=%b en=%b ra=%0d wa=%0d wd=%h, expected all 0", oBUSY, oDONE, mem0writeEN, mem1readADDR, mem0writeADDR, mem0writeDATA);
    end
    exp_q.delete();
    tick();
    vectors++;
    if (oBUSY !== 0) begin
      errs++;
      $display("FAIL abort_stays_idle: busy=%b, expected 0", oBUSY);
    end
    clear_mem0();
    check_run("after_abort", 0, 0);
  endtask
  task automatic test_async_reset();
    push_expect();
    start_pulse();
    for (int c = 1; c < 4; c++) tick();
    #2;
    iRSTn = 0;
    #1;
    vectors++;
    if ({oBUSY, oDONE, mem0writeEN, mem1readADDR, mem0writeADDR, mem0writeDATA} !== '0) begin
      errs++;
      $display("FAIL async_reset_outputs: busy=%b done=%b en=%b ra=%0d wa=%0d wd=%h, expected all 0", oBUSY, oDONE, mem0writeEN, mem1readADDR, mem0writeADDR, mem0writeDATA);
    end
    tick();
    exp_q.delete();
    iRSTn = 1;
    wcount = 0;
    for (int c = 0; c < 5; c++) tick();
    vectors++;
    if (oBUSY !== 0 || oDONE !== 0 || wcount != 0) begin
      errs++;
      $display("FAIL async_reset_idle: busy=%b done=%b writes=%0d, expected 0 0 0", oBUSY, oDONE, wcount);
    end
  endtask
  task automatic test_priority();
    int busy_seen;
    wcount = 0;
    busy_seen = 0;
    iSTART = 1;
    iCLR = 1;
    tick();
    iSTART = 0;
    iCLR = 0;
    for (int c = 0; c < 10; c++) begin
      if (oBUSY) busy_seen++;
      tick();
    end
    vectors++;
    if (busy_seen != 0 || wcount != 0 || oDONE !== 0) begin
      errs++;
      $display("FAIL clr_over_start: busy_cycles=%0d writes=%0d done=%b, expected 0 0 0", busy_seen, wcount, oDONE);
    end
  endtask
  task automatic test_round_trip();
    int busy, done_at, bad;
    for (int n = 0; n < 36; n++) orig[n] = 28'($urandom);
    for (int k = 0; k < 9; k++) mem1[k] = {orig[4 * k], orig[4 * k + 1], orig[4 * k + 2], orig[4 * k + 3]};
    clear_mem0();
    wcount = 0;
    push_expect();
    start_pulse();
    run_collect(0, 0, busy, done_at);
    bad = 0;
    for (int n = 0; n < 36; n++) begin
      vectors++;
      if (mem0[n] !== orig[n]) begin
        errs++;
        $display("FAIL round_trip[%0d]: got %h, expected %h", n, mem0[n], orig[n]);
      end
    end
    vectors++;
    if (wcount != 36 || exp_q.size() != 0) begin
      errs++;
      $display("FAIL round_trip_count: got %0d (left %0d), expected 36 (left 0)", wcount, exp_q.size());
    end
  endtask
  initial begin
    for (int k = 0; k < 16; k++) mem1[k] = '0;
    clear_mem0();
    test_reset();
    test_full_run();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_priority();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
